// File: rtl/seq_mul_param.sv
// seq_mul_param: iterative shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Runtime signed/unsigned mode, busy/done handshake and a held result register.
// Signed operands are reduced to unsigned magnitudes at capture; the sign is
// re-applied when the product is written.
// Optional build macro: SEQ_MUL_EARLY_TERM_EN finishes as soon as the remaining
// multiplier bits are all zero. The product is the same with or without it.
module seq_mul_param #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   op
);

    localparam int PROD_W   = 2 * WIDTH;
    localparam int ACC_W    = 2 * WIDTH + 1;
    localparam int CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int WIDTH_M1 = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = WIDTH_M1[CNT_W-1:0];

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Magnitude of an operand; the most negative value maps onto 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        if (is_signed && v[WIDTH-1]) begin
            magnitude = (~v) + WIDTH'(1);
        end else begin
            magnitude = v;
        end
    endfunction

    // Two's-complement negation of the product when the sign flag is set.
    function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] mag,
                                                     input logic              negate);
        if (negate) begin
            apply_sign = (~mag) + PROD_W'(1);
        end else begin
            apply_sign = mag;
        end
    endfunction

    state_t              state_r;
    logic [ACC_W-1:0]    acc_r;
    logic [WIDTH-1:0]    mcand_r;
    logic [WIDTH-1:0]    mplier_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                neg_r;
    logic                busy_r;
    logic                done_r;
    logic [PROD_W-1:0]   op_r;

    logic [ACC_W-1:0]    add_term_s;
    logic [ACC_W-1:0]    sum_s;
    logic [ACC_W-1:0]    next_acc_s;
    logic                finish_s;
    logic [PROD_W-1:0]   prod_mag_s;
`ifdef SEQ_MUL_EARLY_TERM_EN
    localparam logic [CNT_W:0] WIDTH_C = WIDTH[CNT_W:0];
    logic [CNT_W:0]      shift_amt_s;
`endif

    // One shift-add step: conditional add into the upper half, then align.
    always_comb begin
        add_term_s = '0;
        if (mplier_r[0]) begin
            add_term_s = {1'b0, mcand_r, {WIDTH{1'b0}}};
        end else begin
            add_term_s = '0;
        end
        sum_s      = acc_r + add_term_s;
        next_acc_s = sum_s >> 1;
`ifdef SEQ_MUL_EARLY_TERM_EN
        // Bits shifted out below the product are always zero, so a single
        // variable shift by the outstanding step count aligns the result.
        shift_amt_s = WIDTH_C - {1'b0, cnt_r};
        finish_s    = (cnt_r == LAST_CNT) || ((mplier_r >> 1) == '0);
        prod_mag_s  = PROD_W'(sum_s >> shift_amt_s);
`else
        finish_s    = (cnt_r == LAST_CNT);
        prod_mag_s  = PROD_W'(sum_s >> 1);
`endif
    end

    // Control FSM with registered busy/done/op and operand/accumulator datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            neg_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            op_r     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mcand_r  <= magnitude(a, signed_mode);
                        mplier_r <= magnitude(b, signed_mode);
                        neg_r    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    acc_r    <= next_acc_s;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (finish_s) begin
                        op_r    <= apply_sign(prod_mag_s, neg_r);
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign op   = op_r;

endmodule

// File: tb/tb_seq_mul_param.sv
// Directed testbench for seq_mul_param: one WIDTH=4 and one WIDTH=8 instance
// share clock and reset. Expected latencies depend on SEQ_MUL_EARLY_TERM_EN.
module tb_seq_mul_param;

    logic        clk;
    logic        rst_n;
    logic        start4, sm4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  op4;
    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] op8;

    int tests;
    int fails;

    seq_mul_param #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sm4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .op(op4)
    );

    seq_mul_param #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .op(op8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one operation on the selected instance and observe 24 cycles.
    // lat = edges after capture at which done is seen (-1 if never).
    task automatic run_op(input bit w8, input bit sm, input logic [7:0] av,
                          input logic [7:0] bv, output logic [15:0] res,
                          output logic [15:0] res_end, output int lat,
                          output int busy_n, output int done_n);
        logic cur_busy, cur_done;
        logic [15:0] cur_op;
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; sm8 = sm; a8 = av; b8 = bv;
        end else begin
            start4 = 1'b1; sm4 = sm; a4 = av[3:0]; b4 = bv[3:0];
        end
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
        lat = -1; busy_n = 0; done_n = 0; res = 16'h0000; cur_op = 16'h0000;
        for (int n = 0; n < 24; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            cur_busy = w8 ? busy8 : busy4;
            cur_done = w8 ? done8 : done4;
            cur_op   = w8 ? op8 : {8'h00, op4};
            if (cur_busy) busy_n++;
            if (cur_done) begin
                done_n++;
                if (lat < 0) begin
                    lat = n;
                    res = cur_op;
                end
            end
        end
        res_end = cur_op;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start4 = 1'b0; sm4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        start8 = 1'b0; sm8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        #3;
        tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL reset busy4: got %b expected 0", busy4); end
        tests++; if (done4 !== 1'b0) begin fails++; $display("FAIL reset done4: got %b expected 0", done4); end
        tests++; if (op4 !== 8'h00) begin fails++; $display("FAIL reset op4: got %h expected 00", op4); end
        tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset busy8: got %b expected 0", busy8); end
        tests++; if (op8 !== 16'h0000) begin fails++; $display("FAIL reset op8: got %h expected 0000", op8); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned4();
        logic [15:0] r, re;
        int l, bn, dn;
        run_op(1'b0, 1'b0, 8'd9, 8'd13, r, re, l, bn, dn);
        tests++; if (r !== 16'h0075) begin fails++; $display("FAIL u9x13 op: got %h expected 0075", r); end
        tests++; if (l !== 4) begin fails++; $display("FAIL u9x13 latency: got %0d expected 4", l); end
        tests++; if (bn !== 4) begin fails++; $display("FAIL u9x13 busy cycles: got %0d expected 4", bn); end
        tests++; if (dn !== 1) begin fails++; $display("FAIL u9x13 done pulses: got %0d expected 1", dn); end
        tests++; if (re !== 16'h0075) begin fails++; $display("FAIL u9x13 op held: got %h expected 0075", re); end
        run_op(1'b0, 1'b0, 8'd0, 8'd13, r, re, l, bn, dn);
        tests++; if (r !== 16'h0000) begin fails++; $display("FAIL u0x13 op: got %h expected 0000", r); end
        tests++; if (l !== 4) begin fails++; $display("FAIL u0x13 latency: got %0d expected 4", l); end
    endtask

    task automatic test_signed4();
        logic [15:0] r, re;
        int l, bn, dn, exp_l;
        run_op(1'b0, 1'b1, 8'h08, 8'h08, r, re, l, bn, dn);
        tests++; if (r !== 16'h0040) begin fails++; $display("FAIL s-8x-8 op: got %h expected 0040", r); end
        tests++; if (l !== 4) begin fails++; $display("FAIL s-8x-8 latency: got %0d expected 4", l); end
`ifdef SEQ_MUL_EARLY_TERM_EN
        exp_l = 3;
`else
        exp_l = 4;
`endif
        run_op(1'b0, 1'b1, 8'h08, 8'h07, r, re, l, bn, dn);
        tests++; if (r !== 16'h00C8) begin fails++; $display("FAIL s-8x7 op: got %h expected 00c8", r); end
        tests++; if (l !== exp_l) begin fails++; $display("FAIL s-8x7 latency: got %0d expected %0d", l, exp_l); end
        tests++; if (dn !== 1) begin fails++; $display("FAIL s-8x7 done pulses: got %0d expected 1", dn); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, dn, l1;
        logic [7:0] r1, r2;
        logic busy_after;
`ifdef SEQ_MUL_EARLY_TERM_EN
        l1 = 3;
`else
        l1 = 4;
`endif
        @(negedge clk);
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'd3; b4 = 4'd5;
        @(posedge clk);
        #1;
        a4 = 4'd15; b4 = 4'd15;
        d1 = -1; d2 = -1; dn = 0; r1 = 8'h00; r2 = 8'h00; busy_after = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (n == l1 + 1) busy_after = busy4;
            if (done4) begin
                dn++;
                if (d1 < 0) begin
                    d1 = n; r1 = op4;
                end else if (d2 < 0) begin
                    d2 = n; r2 = op4; start4 = 1'b0;
                end
            end
        end
        start4 = 1'b0;
        tests++; if (r1 !== 8'd15) begin fails++; $display("FAIL b2b first op: got %h expected 0f", r1); end
        tests++; if (d1 !== l1) begin fails++; $display("FAIL b2b first latency: got %0d expected %0d", d1, l1); end
        tests++; if (busy_after !== 1'b1) begin fails++; $display("FAIL b2b no-bubble busy: got %b expected 1", busy_after); end
        tests++; if (r2 !== 8'hE1) begin fails++; $display("FAIL b2b second op: got %h expected e1", r2); end
        tests++; if (d2 !== l1 + 5) begin fails++; $display("FAIL b2b second done edge: got %0d expected %0d", d2, l1 + 5); end
        tests++; if (dn !== 2) begin fails++; $display("FAIL b2b done pulses: got %0d expected 2", dn); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] r, re;
        int l, bn, dn, extra, exp_l;
        @(negedge clk);
        start4 = 1'b1; sm4 = 1'b0; a4 = 4'd7; b4 = 4'd9;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (busy4 !== 1'b0) begin fails++; $display("FAIL midrst busy: got %b expected 0", busy4); end
        tests++; if (done4 !== 1'b0) begin fails++; $display("FAIL midrst done: got %b expected 0", done4); end
        tests++; if (op4 !== 8'h00) begin fails++; $display("FAIL midrst op: got %h expected 00", op4); end
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done4 || busy4) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL midrst activity after release: got %0d expected 0", extra); end
`ifdef SEQ_MUL_EARLY_TERM_EN
        exp_l = 2;
`else
        exp_l = 4;
`endif
        run_op(1'b0, 1'b0, 8'd2, 8'd3, r, re, l, bn, dn);
        tests++; if (r !== 16'h0006) begin fails++; $display("FAIL midrst 2x3 op: got %h expected 0006", r); end
        tests++; if (l !== exp_l) begin fails++; $display("FAIL midrst 2x3 latency: got %0d expected %0d", l, exp_l); end
    endtask

    task automatic test_width8();
        logic [15:0] r, re;
        int l, bn, dn, exp_l;
`ifdef SEQ_MUL_EARLY_TERM_EN
        exp_l = 7;
`else
        exp_l = 8;
`endif
        run_op(1'b1, 1'b1, 8'h80, 8'h7F, r, re, l, bn, dn);
        tests++; if (r !== 16'hC080) begin fails++; $display("FAIL w8 -128x127 op: got %h expected c080", r); end
        tests++; if (l !== exp_l) begin fails++; $display("FAIL w8 -128x127 latency: got %0d expected %0d", l, exp_l); end
        tests++; if (bn !== exp_l) begin fails++; $display("FAIL w8 -128x127 busy cycles: got %0d expected %0d", bn, exp_l); end
        run_op(1'b1, 1'b0, 8'hFF, 8'hFF, r, re, l, bn, dn);
        tests++; if (r !== 16'hFE01) begin fails++; $display("FAIL w8 255x255 op: got %h expected fe01", r); end
        tests++; if (l !== 8) begin fails++; $display("FAIL w8 255x255 latency: got %0d expected 8", l); end
    endtask

    task automatic test_early_term();
        logic [15:0] r, re;
        int l, bn, dn, exp_l;
`ifdef SEQ_MUL_EARLY_TERM_EN
        exp_l = 1;
`else
        exp_l = 8;
`endif
        run_op(1'b1, 1'b0, 8'd200, 8'd1, r, re, l, bn, dn);
        tests++; if (r !== 16'd200) begin fails++; $display("FAIL et 200x1 op: got %0d expected 200", r); end
        tests++; if (l !== exp_l) begin fails++; $display("FAIL et 200x1 latency: got %0d expected %0d", l, exp_l); end
        run_op(1'b1, 1'b0, 8'd200, 8'd0, r, re, l, bn, dn);
        tests++; if (r !== 16'd0) begin fails++; $display("FAIL et 200x0 op: got %0d expected 0", r); end
        tests++; if (l !== exp_l) begin fails++; $display("FAIL et 200x0 latency: got %0d expected %0d", l, exp_l); end
        tests++; if (dn !== 1) begin fails++; $display("FAIL et 200x0 done pulses: got %0d expected 1", dn); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_unsigned4();
        test_signed4();
        test_back_to_back();
        test_reset_mid_run();
        test_width8();
        test_early_term();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
